// File: rtl/mux_gate_pipe.sv
// Two-stage registered logic unit: each result bit is a 2:1 mux selected by the
// matching bit of a. A valid/ready handshake with full backpressure feeds it.
module mux_gate_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [2:0] {
    OP_AND    = 3'd0,
    OP_OR     = 3'd1,
    OP_XOR    = 3'd2,
    OP_NAND   = 3'd3,
    OP_NOR    = 3'd4,
    OP_XNOR   = 3'd5,
    OP_PASS_B = 3'd6,
    OP_NOT_A  = 3'd7
  } op_e;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] a_q, b_q;
  op_e              op_q;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s1_load, s2_load, out_fire;
  logic [WIDTH-1:0] hi, lo;

  assign s2_load  = s1_valid_q & (~s2_valid_q | out_ready);
  assign in_ready = ~s1_valid_q | s2_load;
  assign s1_load  = in_valid & in_ready;
  assign out_fire = s2_valid_q & out_ready;

  // Mux data inputs chosen per function; a[i] then picks hi or lo for bit i.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (latch).
    hi = '0;
    lo = '0;
    unique case (op_q)
      OP_AND:    begin hi = b_q;  lo = '0;   end
      OP_OR:     begin hi = '1;   lo = b_q;  end
      OP_XOR:    begin hi = ~b_q; lo = b_q;  end
      OP_NAND:   begin hi = ~b_q; lo = '1;   end
      OP_NOR:    begin hi = '0;   lo = ~b_q; end
      OP_XNOR:   begin hi = b_q;  lo = ~b_q; end
      OP_PASS_B: begin hi = b_q;  lo = b_q;  end
      OP_NOT_A:  begin hi = '0;   lo = '1;   end
      default:   begin hi = '0;   lo = '0;   end
    endcase
  end

  always_comb begin
    y_d = y_q;
    if (s2_load) begin
      for (int i = 0; i < WIDTH; i++) begin
        y_d[i] = a_q[i] ? hi[i] : lo[i];
      end
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    if (s1_load)      s1_valid_d = 1'b1;
    else if (s2_load) s1_valid_d = 1'b0;

    s2_valid_d = s2_valid_q;
    if (s2_load)        s2_valid_d = 1'b1;
    else if (out_fire)  s2_valid_d = 1'b0;

    cnt_d = out_fire ? cnt_q + 1'b1 : cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= OP_AND;
      y_q        <= '0;
      cnt_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      y_q        <= y_d;
      cnt_q      <= cnt_d;
      if (s1_load) begin
        a_q  <= a;
        b_q  <= b;
        op_q <= op_e'(op);
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign y         = y_q;
  assign op_count  = cnt_q;

endmodule

// File: tb/tb_mux_gate_pipe.sv
// Self-checking bench for mux_gate_pipe: vector table plus scoreboard-driven
// streams covering backpressure, simultaneous accept/drain, wrap and reset.
module tb_mux_gate_pipe;

  localparam int WIDTH = 8;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic [2:0]       op = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] y;
  logic [CNT_W-1:0] op_count;

  mux_gate_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic [WIDTH-1:0] exp_y;
  } vec_t;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [WIDTH-1:0] exp_q[$];
  int               acc_q[$];
  logic [CNT_W-1:0] exp_cnt = '0;
  bit               last_acc = 0;
  bit               check_lat = 0;
  bit               toggle_rdy = 0;
  bit               use_override = 0;
  logic [WIDTH-1:0] exp_override = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_fn(input logic [WIDTH-1:0] ra,
                                              input logic [WIDTH-1:0] rb,
                                              input logic [2:0] rop);
    case (rop)
      3'd0: return ra & rb;
      3'd1: return ra | rb;
      3'd2: return ra ^ rb;
      3'd3: return ~(ra & rb);
      3'd4: return ~(ra | rb);
      3'd5: return ~(ra ^ rb);
      3'd6: return rb;
      default: return ~ra;
    endcase
  endfunction

  // One clock cycle: sample at the negedge, score handshakes, advance past posedge.
  task automatic cycle();
    logic [WIDTH-1:0] e;
    int c;
    @(negedge clk);
    check("op_count", 32'(op_count), 32'(exp_cnt));
    last_acc = 0;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got y=%0h expected no output (t=%0t)", y, $time);
      end else begin
        e = exp_q.pop_front();
        c = acc_q.pop_front();
        check("y", 32'(y), 32'(e));
        if (check_lat) check("latency", 32'(cyc - c), 32'd2);
      end
      exp_cnt = exp_cnt + 1'b1;
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(use_override ? exp_override : ref_fn(a, b, op));
      acc_q.push_back(cyc);
      last_acc = 1;
    end
    cyc++;
    @(posedge clk);
    #1;
    if (toggle_rdy) out_ready = ~out_ready;
  endtask

  task automatic send(input logic [WIDTH-1:0] sa, input logic [WIDTH-1:0] sb,
                      input logic [2:0] sop);
    int n;
    a = sa; b = sb; op = sop; in_valid = 1'b1;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!last_acc && n < 20);
    if (!last_acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no accept expected accept within 20 cycles");
    end
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    n = 0;
    while (exp_q.size() > 0 && n < 50) begin
      cycle();
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    repeat (3) cycle();
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    out_ready = 1'b0;
    toggle_rdy = 0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_op_count", 32'(op_count), 32'd0);
    exp_q.delete();
    acc_q.delete();
    exp_cnt = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
  endtask

  vec_t sweep[8];

  initial begin
    sweep[0] = '{8'hF0, 8'hCC, 3'd0, 8'hC0};
    sweep[1] = '{8'hF0, 8'hCC, 3'd1, 8'hFC};
    sweep[2] = '{8'hF0, 8'hCC, 3'd2, 8'h3C};
    sweep[3] = '{8'hF0, 8'hCC, 3'd3, 8'h3F};
    sweep[4] = '{8'hF0, 8'hCC, 3'd4, 8'h03};
    sweep[5] = '{8'hF0, 8'hCC, 3'd5, 8'hC3};
    sweep[6] = '{8'hF0, 8'hCC, 3'd6, 8'hCC};
    sweep[7] = '{8'hF0, 8'hCC, 3'd7, 8'h0F};

    // Reset / idle
    #1;
    do_reset();
    repeat (2) cycle();
    check("idle_out_valid", 32'(out_valid), 32'd0);

    // Function sweep, back to back with out_ready high, table-defined results
    out_ready = 1'b1;
    check_lat = 1;
    use_override = 1;
    for (int i = 0; i < 8; i++) begin
      exp_override = sweep[i].exp_y;
      send(sweep[i].a, sweep[i].b, sweep[i].op);
    end
    use_override = 0;
    drain();
    check_lat = 0;

    // Backpressure: two words held, in_ready low, y stable on first result
    do_reset();
    send(8'hA5, 8'h3C, 3'd2);
    send(8'h0F, 8'hFF, 3'd0);
    a = 8'h55; b = 8'h0F; op = 3'd1; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_y_hold", 32'(y), 32'(exp_q[0]));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    send(8'h55, 8'h0F, 3'd1);
    send(8'hC3, 8'h96, 3'd5);
    drain();
    check("bp_op_count", 32'(op_count), 32'd4);

    // Full occupancy with out_ready toggling while new words keep arriving
    do_reset();
    send(8'h12, 8'h34, 3'd3);
    send(8'h56, 8'h78, 3'd4);
    out_ready = 1'b1;
    toggle_rdy = 1;
    for (int i = 0; i < 8; i++) begin
      send(WIDTH'($urandom), WIDTH'($urandom), 3'($urandom_range(0, 7)));
    end
    drain();
    toggle_rdy = 0;
    check("toggle_op_count", 32'(op_count), 32'd2);

    // Counter wrap with a 3-bit counter: nine handshakes end at 1
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      send(WIDTH'(i * 37), WIDTH'(~i), 3'(i));
    end
    drain();
    check("wrap_op_count", 32'(op_count), 32'd1);

    // Reset mid-stream with both stages full
    out_ready = 1'b0;
    send(8'hDE, 8'hAD, 3'd0);
    send(8'hBE, 8'hEF, 3'd1);
    check("mid_full_in_ready", 32'(in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_op_count", 32'(op_count), 32'd0);
    check("mid_rst_y", 32'(y), 32'd0);
    in_valid = 1'b0;
    exp_q.delete();
    acc_q.delete();
    exp_cnt = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(8'h3C, 8'h5A, 3'd2);
    drain();
    check("mid_after_op_count", 32'(op_count), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_gate_pipe.md
# mux_gate_pipe

Parametrised, pipelined successor to the single-bit mux-built AND gate. Each of WIDTH bit lanes evaluates one of eight two-input logic functions, every function built only from a per-bit 2:1 mux selected by A. Operands enter through a valid/ready handshake and pass through a two-stage registered pipeline with full backpressure. A wrapping counter records the number of completed results. The block is a drop-in registered logic unit for datapaths that previously used the combinational gate.

## Interface
- WIDTH, 8, operand/result width in bits (≥1)
- CNT_W, 16, width of the completed-result counter (≥1)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand word valid
- in_ready  out  1  block can accept operand word this cycle
- a  in  WIDTH  operand A (mux select per bit)
- b  in  WIDTH  operand B
- op  in  3  function select, sampled with a/b
- out_valid  out  1  y holds a valid result
- out_ready  in  1  downstream accepts y this cycle
- y  out  WIDTH  result
- op_count  out  CNT_W  number of results accepted downstream, wrapping

## Operation
- Per bit i, y[i] = a[i] ? hi : lo, where (hi, lo) by op:
  - 0 AND: (b, 0)
  - 1 OR: (1, b)
  - 2 XOR: (~b, b)
  - 3 NAND: (~b, 1)
  - 4 NOR: (0, ~b)
  - 5 XNOR: (b, ~b)
  - 6 PASS_B: (b, b)
  - 7 NOT_A: (0, 1)
- Stage 1 (S1) registers a, b and op on input accept (in_valid & in_ready); s1_valid is set.
- Stage 2 (S2) registers the mux result computed from S1 contents; s2_valid drives out_valid; the S2 data register drives y.
- Advance rules: S2 loads when S1 is valid and (!s2_valid | out_ready). S1 loads when in_valid and (!s1_valid | S2 loads). in_ready = !s1_valid | S2-load condition (combinational, no dependency on in_valid).
- If S2 drains (out_valid & out_ready) with no S1 data to load, s2_valid clears. If S1 hands data to S2 with no new input, s1_valid clears.
- op_count increments by 1 on each output handshake (out_valid & out_ready). It wraps from 2^CNT_W−1 to 0 with no flag.
- y, a/b/op capture registers hold their value while stalled. y is not modified while out_valid=1 and out_ready=0.
- out_ready with out_valid=0 is ignored. in_valid with in_ready=0 is not a transfer, and the upstream must hold a/b/op stable.

## Timing
- Reset (rst_n low, asynchronous, takes effect immediately): s1_valid=0, s2_valid=0, out_valid=0, y=0, op_count=0. in_ready=1 as soon as reset deasserts (combinational from s1_valid=0).
- Reset mid-operation: all in-flight words are discarded and no partial result appears on y. After deassertion, the first accept occurs on the first rising edge with in_valid=1.
- Latency: a word accepted at edge N appears with out_valid=1 after edge N+1 (visible in cycle N+1 to N+2). Two register stages means 2 edges from a/b presented to y, with out_ready held at 1.
- Throughput: 1 word/cycle with out_ready held 1. No bubbles are inserted.
- Backpressure: with out_ready=0, at most 2 words are held (S2 and S1). in_ready falls to 0 only once both stages are valid. When out_ready returns to 1, in_ready=1 in that same cycle.
- Simultaneous events: input accept and output handshake in the same cycle, with both stages full, shift the pipeline and keep it full. op_count increments on the same edge as the drain.
- op_count updates on the edge of the handshake and is visible in the following cycle.

## Test plan
- Reset/idle: rst_n=0 then 1 with in_valid=0 → out_valid=0, y=0, op_count=0, in_ready=1.
- Function sweep, WIDTH=8, out_ready=1: a=8'hF0, b=8'hCC, op=0..7 on consecutive cycles → y = C0, FC, 3C, 3F, 03, C3, CC, 0F in order, each 2 edges after accept, no gaps.
- Backpressure: stream 4 words with out_ready=0 → in_ready drops after 2 accepts, y stable on the first result. Raising out_ready releases all 4 in order, op_count ends at 4.
- Simultaneous accept/drain at full occupancy, with out_ready toggling 1,0,1,0 → no word lost or duplicated, and output order matches input order.
- Counter wrap, CNT_W=3: 9 handshakes → op_count sequence 1…7, 0, 1.
- Reset mid-stream: assert rst_n=0 asynchronously while both stages are valid → out_valid drops without waiting for a clock edge, and op_count=0. After release, the next word's result is correct and no stale word is emitted.
